// File: rtl/tt_um_down_timer.sv
// Prescaled, loadable down-counting timer with one-shot or auto-reload expiry.
// Auto-reload exists only when TT_UM_DOWN_TIMER_PERIODIC_EN is defined; otherwise every run is one-shot.
module tt_um_down_timer #(
  parameter int BW    = 8,
  parameter int PS_BW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BW-1:0]    load_val_i,
  input  logic [PS_BW-1:0] prescale_i,
  input  logic             periodic_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             done_clr_i,
  output logic [BW-1:0]    count_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [BW-1:0]    CNT_ONE = BW'(1);
  localparam logic [PS_BW-1:0] PS_ONE  = PS_BW'(1);

  logic [1:0]       state_q;
  logic [BW-1:0]    count_q;
  logic [PS_BW-1:0] ps_q;
  logic [PS_BW-1:0] pc_q;
  logic             tick_q;
  logic             done_q;
  logic             busy_q;

`ifdef TT_UM_DOWN_TIMER_PERIODIC_EN
  logic             mode_q;
  logic [BW-1:0]    reload_q;
`else
  logic             unused_periodic;
  assign unused_periodic = periodic_i;
`endif

  // A start with a zero load value is treated as if start were not asserted.
  logic start_ok;
  assign start_ok = start_i && (load_val_i != '0);

  always_ff @(posedge clk_i) begin
    tick_q <= 1'b0;
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      ps_q     <= '0;
      pc_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TT_UM_DOWN_TIMER_PERIODIC_EN
      mode_q   <= 1'b0;
      reload_q <= '0;
`endif
    end else if (stop_i) begin
      // Stop beats start in every state, but only RUN has anything to halt.
      if (state_q == S_RUN) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        pc_q    <= '0;
      end
    end else if (start_ok) begin
      count_q  <= load_val_i;
      ps_q     <= prescale_i;
      pc_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
      state_q  <= S_RUN;
`ifdef TT_UM_DOWN_TIMER_PERIODIC_EN
      mode_q   <= periodic_i;
      reload_q <= load_val_i;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (pc_q == ps_q) begin
            pc_q <= '0;
            if (count_q > CNT_ONE) begin
              count_q <= count_q - CNT_ONE;
`ifdef TT_UM_DOWN_TIMER_PERIODIC_EN
            end else if (mode_q) begin
              count_q <= reload_q;
              tick_q  <= 1'b1;
`endif
            end else begin
              count_q <= '0;
              tick_q  <= 1'b1;
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            pc_q <= pc_q + PS_ONE;
          end
        end
        S_DONE: begin
          if (done_clr_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_tt_um_down_timer.sv
// Vector table plus hand sequences for tt_um_down_timer; expectations are queued
// when inputs are driven and compared once the edge that consumes them has passed.
module tb_tt_um_down_timer;

  logic       clk_i = 1'b0;
  logic       rst_i, periodic_i, start_i, stop_i, done_clr_i;
  logic [7:0] load_val_i;
  logic [3:0] prescale_i;
  logic [7:0] count_o;
  logic       busy_o, tick_o, done_o;

  tt_um_down_timer #(.BW(8), .PS_BW(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_val_i(load_val_i), .prescale_i(prescale_i),
    .periodic_i(periodic_i), .start_i(start_i), .stop_i(stop_i), .done_clr_i(done_clr_i),
    .count_o(count_o), .busy_o(busy_o), .tick_o(tick_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst, start, stop, clr, per;
    logic [7:0] load;
    logic [3:0] ps;
    logic [7:0] e_cnt;
    logic       e_busy, e_tick, e_done;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       busy, tick, done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic start, input logic stop, input logic clr,
                     input logic [7:0] load, input logic [3:0] ps, input logic per,
                     input logic [7:0] cnt, input logic busy, input logic tick, input logic done);
    vec_t v;
    v.rst = rst; v.start = start; v.stop = stop; v.clr = clr; v.per = per;
    v.load = load; v.ps = ps;
    v.e_cnt = cnt; v.e_busy = busy; v.e_tick = tick; v.e_done = done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    static int idx = 0;
    rst_i = v.rst; start_i = v.start; stop_i = v.stop; done_clr_i = v.clr;
    load_val_i = v.load; prescale_i = v.ps; periodic_i = v.per;
    e.cnt = v.e_cnt; e.busy = v.e_busy; e.tick = v.e_tick; e.done = v.e_done;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    idx++;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s step %0d: scoreboard empty", name, idx);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".count"}, idx, count_o, e.cnt);
      chk({name, ".busy"},  idx, {7'd0, busy_o}, {7'd0, e.busy});
      chk({name, ".tick"},  idx, {7'd0, tick_o}, {7'd0, e.tick});
      chk({name, ".done"},  idx, {7'd0, done_o}, {7'd0, e.done});
    end
  endtask

  task automatic do1(input string name, input logic rst, input logic start, input logic stop,
                     input logic clr, input logic [7:0] load, input logic [3:0] ps, input logic per,
                     input logic [7:0] cnt, input logic busy, input logic tick, input logic done);
    vec_t v;
    v.rst = rst; v.start = start; v.stop = stop; v.clr = clr; v.per = per;
    v.load = load; v.ps = ps;
    v.e_cnt = cnt; v.e_busy = busy; v.e_tick = tick; v.e_done = done;
    step(name, v);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; done_clr_i = 1'b0;
    load_val_i = '0; prescale_i = '0; periodic_i = 1'b0;

    //   rst st sp clr load ps per | cnt busy tick done
    // reset, then one-shot N=3 P=0
    add(1, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 8'd3, 4'd0, 0,   8'd3, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd2, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd1, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 1, 1);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 0, 1);
    add(0, 0, 0, 1, 8'd0, 4'd0, 0,   8'd0, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 0, 0);
    // prescale N=2 P=3: four clocks per value, tick 8 clocks after start
    add(0, 1, 0, 0, 8'd2, 4'd3, 0,   8'd2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd2, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd1, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 1, 1);
    // start together with done_clr from DONE: start wins
    add(0, 1, 0, 1, 8'd1, 4'd0, 0,   8'd1, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 1, 1);
    add(0, 0, 0, 1, 8'd0, 4'd0, 0,   8'd0, 0, 0, 0);
    // stop with start at count 3, then zero-load start, then lone stop in IDLE
    add(0, 1, 0, 0, 8'd5, 4'd0, 0,   8'd5, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd4, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd3, 1, 0, 0);
    add(0, 1, 1, 0, 8'd9, 4'd0, 0,   8'd3, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd3, 0, 0, 0);
    add(0, 1, 0, 0, 8'd0, 4'd2, 0,   8'd3, 0, 0, 0);
    add(0, 0, 1, 0, 8'd0, 4'd0, 0,   8'd3, 0, 0, 0);
    // re-arm N=2 -> N=6 on the expiring edge: no tick, then tick 6 clocks later
    add(0, 1, 0, 0, 8'd2, 4'd0, 0,   8'd2, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd1, 1, 0, 0);
    add(0, 1, 0, 0, 8'd6, 4'd0, 0,   8'd6, 1, 0, 0);
    for (int i = 5; i >= 1; i--) add(0, 0, 0, 0, 8'd0, 4'd0, 0, 8'(i), 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd0, 0, 1, 1);
    add(0, 0, 0, 1, 8'd0, 4'd0, 0,   8'd0, 0, 0, 0);
    // maximum load value counts down without wrapping
    add(0, 1, 0, 0, 8'd255, 4'd0, 0, 8'd255, 1, 0, 0);
    add(0, 0, 0, 0, 8'd0, 4'd0, 0,   8'd254, 1, 0, 0);
    add(0, 0, 1, 0, 8'd0, 4'd0, 0,   8'd254, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step("table", vecs[i]);

    // periodic N=4 P=0 for three full periods
    do1("per", 0, 1, 0, 0, 8'd4, 4'd0, 1, 8'd4, 1, 0, 0);
`ifdef TT_UM_DOWN_TIMER_PERIODIC_EN
    for (int k = 1; k <= 12; k++)
      do1("per", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'(4 - (k % 4)), 1, (k % 4) == 0, 0);
    do1("per_stop", 0, 0, 1, 0, 8'd0, 4'd0, 0, 8'd4, 0, 0, 0);
`else
    for (int k = 1; k <= 3; k++)
      do1("per", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'(4 - k), 1, 0, 0);
    do1("per", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd0, 0, 1, 1);
    for (int k = 0; k < 4; k++)
      do1("per_hold", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 1);
    do1("per_clr", 0, 0, 0, 1, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0);
`endif

    // reset in the middle of a long run
    do1("midrst", 0, 1, 0, 0, 8'd200, 4'd0, 0, 8'd200, 1, 0, 0);
    for (int k = 1; k <= 50; k++)
      do1("midrst", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'(200 - k), 1, 0, 0);
    do1("midrst", 1, 0, 0, 0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0);
    do1("midrst", 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
